// File: rtl/int_ctrl18_pkg.sv
// Shared types and constants for the Core18 interrupt controller.
// Holds the controller state encoding, register offsets and address helper.
package int_ctrl18_pkg;

    localparam int NUM_IRQ = 15;
    localparam int DATA_W  = 18;
    localparam int VEC_W   = 4;

    // The encoding is visible to software through STAT, so keep IDLE at zero.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;

    function automatic logic [DATA_W-1:0] reg_adrs(input logic [DATA_W-1:0] base,
                                                   input logic [1:0]        off);
        return base + DATA_W'(off);
    endfunction

endpackage

// File: rtl/int_ctrl18_if.sv
// Core18 port bus as seen by a peripheral: strobes, address, write data, read data.
interface int_ctrl18_if;
    import int_ctrl18_pkg::*;

    logic              port_wr;
    logic              port_rd;
    logic [DATA_W-1:0] adrs;
    logic [DATA_W-1:0] dataout;
    logic [DATA_W-1:0] port_data;

    modport master (output port_wr, port_rd, adrs, dataout, input port_data);
    modport slave  (input port_wr, port_rd, adrs, dataout, output port_data);

endinterface

// File: rtl/int_prio15.sv
// Combinational 15-to-4 priority encoder: reports the highest set index.
module int_prio15
    import int_ctrl18_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    // Ascending scan so the highest set bit is the last assignment to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx   = VEC_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl18.sv
// Core18 interrupt controller: edge-latched requests, MASK/PEND/STAT registers, timed vector issue.
// Define INT_CTRL18_SYNC_EN to add a two-flop synchronizer on every IRQ line.
module int_ctrl18
    import int_ctrl18_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE_ADRS = 18'o000040,
    parameter int                HOLD      = 2,
    parameter int                GAP       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [NUM_IRQ-1:0] irq,
    int_ctrl18_if.slave        bus,
    output logic [VEC_W-1:0]   vector
);

    localparam logic [DATA_W-1:0] ADRS_MASK = reg_adrs(BASE_ADRS, REG_MASK);
    localparam logic [DATA_W-1:0] ADRS_PEND = reg_adrs(BASE_ADRS, REG_PEND);
    localparam logic [DATA_W-1:0] ADRS_STAT = reg_adrs(BASE_ADRS, REG_STAT);

`ifdef INT_CTRL18_SYNC_EN
    localparam int PRIME_W = 4;
    logic [NUM_IRQ-1:0] sync1;
    logic [NUM_IRQ-1:0] sync2;
`else
    localparam int PRIME_W = 2;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic [VEC_W-1:0]   vector_nxt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_smp;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] issue_clr;
    logic [NUM_IRQ-1:0] w1c;
    logic [PRIME_W-1:0] primed;
    logic [VEC_W-1:0]   win_idx;
    logic               win_valid;
    logic               unused_dataout;

`ifdef INT_CTRL18_SYNC_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
        end
    end
    assign irq_in = sync2;
`else
    assign irq_in = irq;
`endif

    // Zeros left by reset are not real samples; a line held high across reset must not look like a rise.
    assign irq_rise       = primed[PRIME_W-1] ? (irq_smp & ~irq_prev) : '0;
    assign eligible       = pend & mask;
    assign w1c            = (bus.port_wr && bus.adrs == ADRS_PEND) ? bus.dataout[NUM_IRQ-1:0] : '0;
    assign pend_nxt       = (pend & ~w1c & ~issue_clr) | irq_rise;
    assign unused_dataout = ^bus.dataout[DATA_W-1:NUM_IRQ];

    int_prio15 u_prio (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            vector   <= '0;
            mask     <= '0;
            pend     <= '0;
            irq_smp  <= '0;
            irq_prev <= '0;
            primed   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            vector   <= vector_nxt;
            pend     <= pend_nxt;
            irq_smp  <= irq_in;
            irq_prev <= irq_smp;
            primed   <= {primed[PRIME_W-2:0], 1'b1};
            if (bus.port_wr && bus.adrs == ADRS_MASK) begin
                mask <= bus.dataout[NUM_IRQ-1:0];
            end
        end
    end

    // cnt holds the remaining cycles of the current ISSUE or GAP phase minus one.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        vector_nxt = vector;
        issue_clr  = '0;
        unique case (state)
            ST_IDLE: begin
                if (run && win_valid) begin
                    state_nxt  = ST_ISSUE;
                    cnt_nxt    = 4'(HOLD - 1);
                    vector_nxt = win_idx + 4'd1;
                    issue_clr  = NUM_IRQ'(1) << win_idx;
                end
            end
            ST_ISSUE: begin
                if (cnt == 4'd0) begin
                    state_nxt  = ST_GAP;
                    cnt_nxt    = 4'(GAP - 1);
                    vector_nxt = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                cnt_nxt    = '0;
                vector_nxt = '0;
            end
        endcase
    end

    always_comb begin
        bus.port_data = '0;
        if (bus.port_rd) begin
            if (bus.adrs == ADRS_MASK) begin
                bus.port_data = DATA_W'(mask);
            end else if (bus.adrs == ADRS_PEND) begin
                bus.port_data = DATA_W'(pend);
            end else if (bus.adrs == ADRS_STAT) begin
                bus.port_data = DATA_W'({state, vector});
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl18.sv
// Self-checking bench for int_ctrl18: directed scenarios plus randomized traffic
// against a time-based reference model of the interrupt controller.
`timescale 1ns/1ps
module tb_int_ctrl18;
    import int_ctrl18_pkg::*;

    localparam logic [17:0] BASE   = 18'o000040;
    localparam logic [17:0] A_MASK = BASE;
    localparam logic [17:0] A_PEND = BASE + 18'd1;
    localparam logic [17:0] A_STAT = BASE + 18'd2;
    localparam int          HOLD_C = 2;
    localparam int          GAP_C  = 2;
`ifdef INT_CTRL18_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [14:0] irq;
    logic [3:0]  vector;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl18_if bus ();

    int_ctrl18 #(.BASE_ADRS(BASE), .HOLD(HOLD_C), .GAP(GAP_C)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .irq    (irq),
        .bus    (bus),
        .vector (vector)
    );

    always #5 clk = ~clk;

    // Reference model: issue timing is tracked as absolute edge numbers rather than a state machine.
    int          t = 0;
    int          last_issue = 0;
    bit          have_issue = 0;
    logic [14:0] m_pend = '0;
    logic [14:0] m_mask = '0;
    logic [3:0]  m_vec = '0;
    logic [3:0]  issue_vec = '0;
    logic [1:0]  m_state = '0;
    logic [14:0] hist [0:4];
    bit          hist_v [0:4];

    always @(posedge clk) begin : model
        logic [14:0] rise;
        logic [14:0] clr;
        logic [14:0] take;
        t = t + 1;
        if (reset) begin
            m_pend     = '0;
            m_mask     = '0;
            have_issue = 0;
            for (int i = 0; i < 5; i++) begin
                hist[i]   = '0;
                hist_v[i] = 0;
            end
        end else begin
            rise = '0;
            if (hist_v[SYNC_DLY] && hist_v[SYNC_DLY+1])
                rise = hist[SYNC_DLY] & ~hist[SYNC_DLY+1];
            clr  = (bus.port_wr && bus.adrs == A_PEND) ? bus.dataout[14:0] : '0;
            take = '0;
            if (run && (m_pend & m_mask) != '0 &&
                (!have_issue || t > last_issue + HOLD_C + GAP_C)) begin
                for (int n = 0; n < 15; n++) begin
                    if (m_pend[n] && m_mask[n]) begin
                        take      = 15'(1) << n;
                        issue_vec = 4'(n + 1);
                    end
                end
                last_issue = t;
                have_issue = 1;
            end
            if (bus.port_wr && bus.adrs == A_MASK) m_mask = bus.dataout[14:0];
            m_pend = (m_pend & ~clr & ~take) | rise;
            for (int i = 4; i > 0; i--) begin
                hist[i]   = hist[i-1];
                hist_v[i] = hist_v[i-1];
            end
            hist[0]   = irq;
            hist_v[0] = 1;
        end
        if (have_issue && t < last_issue + HOLD_C) begin
            m_vec   = issue_vec;
            m_state = 2'd1;
        end else if (have_issue && t < last_issue + HOLD_C + GAP_C) begin
            m_vec   = '0;
            m_state = 2'd2;
        end else begin
            m_vec   = '0;
            m_state = 2'd0;
        end
    end

    task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got %0d, want %0d", name, t, act, exp);
        end
    endtask

    // Every cycle advance compares the vector against the model.
    task automatic step();
        @(negedge clk);
        checkOutput("vector_model", 18'(vector), 18'(m_vec));
    endtask

    task automatic applyStimulus(input logic [14:0] irq_v, input logic run_v, input logic reset_v);
        irq   = irq_v;
        run   = run_v;
        reset = reset_v;
    endtask

    task automatic readCheck(input string name, input logic [17:0] a, input logic [17:0] exp);
        bus.port_rd = 1'b1;
        bus.adrs    = a;
        #1;
        checkOutput(name, bus.port_data, exp);
        bus.port_rd = 1'b0;
    endtask

    task automatic writeReg(input logic [17:0] a, input logic [17:0] d);
        bus.port_wr = 1'b1;
        bus.adrs    = a;
        bus.dataout = d;
        step();
        bus.port_wr = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        bit          found;
        int          off;
        int          r;
        logic [17:0] exp;
        applyStimulus('0, 1'b1, 1'b1);
        bus.port_wr = 1'b0;
        bus.port_rd = 1'b0;
        bus.adrs    = '0;
        bus.dataout = '0;
        doReset();

        checkOutput("reset_vector", 18'(vector), 18'd0);
        readCheck("reset_mask", A_MASK, 18'd0);
        readCheck("reset_pend", A_PEND, 18'd0);
        readCheck("reset_stat", A_STAT, 18'd0);

        // Register decode: upper MASK bits read zero, STAT ignores writes, no data without a read.
        writeReg(A_MASK, 18'h3FFFF);
        readCheck("mask_width", A_MASK, 18'h07FFF);
        writeReg(A_STAT, 18'h3FFFF);
        readCheck("stat_ro", A_STAT, 18'd0);
        readCheck("unmapped_read", BASE + 18'd3, 18'd0);
        bus.adrs = A_MASK;
        #1;
        checkOutput("no_rd_strobe", bus.port_data, 18'd0);

        // Single IRQ[6] pulse, exact latency and hold/gap timing.
        writeReg(A_MASK, 18'h0007F);
        irq[6] = 1'b1;
        step();
        irq = '0;
        step();
        repeat (SYNC_DLY) step();
        checkOutput("req33_before", 18'(vector), 18'd0);
        step();
        checkOutput("req33_hold1", 18'(vector), 18'd7);
        readCheck("req33_stat", A_STAT, 18'h17);
        step();
        checkOutput("req33_hold2", 18'(vector), 18'd7);
        step();
        checkOutput("req33_gap1", 18'(vector), 18'd0);
        readCheck("req33_stat_gap", A_STAT, 18'h20);
        step();
        checkOutput("req33_gap2", 18'(vector), 18'd0);
        readCheck("req33_pend", A_PEND, 18'd0);
        repeat (3) step();

        // Simultaneous IRQ[2] and IRQ[9]: higher first, lower after the gap.
        writeReg(A_MASK, 18'h07FFF);
        irq = 15'((1 << 2) | (1 << 9));
        step();
        irq = '0;
        step();
        repeat (SYNC_DLY) step();
        step();
        checkOutput("req34_first", 18'(vector), 18'd10);
        step();
        repeat (3) step();
        checkOutput("req34_idle", 18'(vector), 18'd0);
        step();
        checkOutput("req34_second", 18'(vector), 18'd3);
        repeat (6) step();

        // Masked request stays pending until enabled.
        writeReg(A_MASK, 18'd0);
        irq[4] = 1'b1;
        step();
        irq = '0;
        repeat (6 + SYNC_DLY) step();
        checkOutput("req35_masked", 18'(vector), 18'd0);
        readCheck("req35_pend", A_PEND, 18'o000020);
        writeReg(A_MASK, 18'o000020);
        step();
        checkOutput("req35_unmask", 18'(vector), 18'd5);
        repeat (6) step();

        // New edge coinciding with W1C of the same bit keeps it pending.
        writeReg(A_MASK, 18'd0);
        irq[4] = 1'b1;
        step();
        irq = '0;
        step();
        repeat (SYNC_DLY) step();
        readCheck("req36_pend_set", A_PEND, 18'o000020);
        irq[4] = 1'b1;
        step();
        irq = '0;
        repeat (SYNC_DLY) step();
        writeReg(A_PEND, 18'o000020);
        readCheck("req36_set_wins", A_PEND, 18'o000020);
        writeReg(A_PEND, 18'o000020);
        readCheck("req36_w1c", A_PEND, 18'd0);

        // Reset in the middle of an issue.
        writeReg(A_MASK, 18'h0007F);
        irq[6] = 1'b1;
        step();
        irq = '0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (vector == 4'd7) found = 1;
        end
        checkOutput("req37_reach_issue", 18'(found), 18'd1);
        reset = 1'b1;
        step();
        checkOutput("req37_vector", 18'(vector), 18'd0);
        readCheck("req37_mask", A_MASK, 18'd0);
        readCheck("req37_pend", A_PEND, 18'd0);
        readCheck("req37_stat", A_STAT, 18'd0);
        reset = 1'b0;
        repeat (4) step();

        // Line held high across reset is not an edge until it drops and rises again.
        irq[3] = 1'b1;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (6) step();
        readCheck("req28_no_edge", A_PEND, 18'd0);
        irq[3] = 1'b0;
        step();
        step();
        irq[3] = 1'b1;
        repeat (3 + SYNC_DLY) step();
        readCheck("req28_edge", A_PEND, 18'd8);
        irq = '0;
        writeReg(A_PEND, 18'd8);

        // RUN low blocks issue; raising it releases the pending vector.
        run = 1'b0;
        writeReg(A_MASK, 18'd1);
        irq[0] = 1'b1;
        step();
        irq = '0;
        repeat (8) step();
        checkOutput("req38_blocked", 18'(vector), 18'd0);
        readCheck("req38_pend", A_PEND, 18'd1);
        run = 1'b1;
        step();
        checkOutput("req38_release", 18'(vector), 18'd1);
        repeat (6) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 15; b++) begin
                if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
            end
            run         = ($urandom_range(0, 7) != 0);
            reset       = ($urandom_range(0, 499) == 0);
            bus.port_wr = 1'b0;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                bus.port_wr = 1'b1;
                bus.adrs    = A_MASK;
                bus.dataout = 18'($urandom);
            end else if (r == 1) begin
                bus.port_wr = 1'b1;
                bus.adrs    = A_PEND;
                bus.dataout = 18'($urandom);
            end else if (r < 5) begin
                off = $urandom_range(0, 3);
                case (off)
                    0:       exp = 18'(m_mask);
                    1:       exp = 18'(m_pend);
                    2:       exp = 18'({m_state, m_vec});
                    default: exp = 18'd0;
                endcase
                readCheck("rand_read", BASE + 18'(off), exp);
            end
            step();
        end
        bus.port_wr = 1'b0;
        applyStimulus('0, 1'b1, 1'b0);
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl18.md
INT_CTRL18 -- requirements
Module: int_ctrl18

Interface
REQ-001 Parameter BASE_ADRS, default 18'o000040, is the port address of register 0; registers occupy BASE_ADRS..BASE_ADRS+2.
REQ-002 Parameter HOLD, default 2, is the number of cycles VECTOR stays non-zero per interrupt, range 1..15.
REQ-003 Parameter GAP, default 2, is the number of cycles VECTOR is forced to 0 after a hold, range 1..15.
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 RUN  in  1  core run enable; no vector is issued while low.
REQ-007 IRQ  in  15  interrupt request lines, rising-edge sensitive; IRQ[n] maps to vector n+1.
REQ-008 PORT_WR  in  1  core port write strobe.
REQ-009 PORT_RD  in  1  core port read strobe.
REQ-010 ADRS  in  18  core port address.
REQ-011 DATAOUT  in  18  core write data.
REQ-012 VECTOR  out  4  interrupt vector to Core18; 0 = none.
REQ-013 PORT_DATA  out  18  read data; 0 unless an own register is read.

Function
REQ-014 A rising edge on IRQ[n] (sample high, previous sample low) shall set PEND[n] regardless of MASK.
REQ-015 Register 0 (MASK, 15 bits, R/W) shall be written from DATAOUT[14:0] when PORT_WR=1 and ADRS=BASE_ADRS; 1 = enabled.
REQ-016 Register 1 (PEND) shall read pending bits; a write shall clear each PEND bit whose DATAOUT bit is 1 (W1C).
REQ-017 Register 2 (STAT) read shall return {state[1:0], current vector[3:0]} in bits [5:0], upper bits 0; writes ignored.
REQ-018 PORT_DATA shall be combinational, valid the same cycle PORT_RD=1 and ADRS matches; bits above 14 zero for MASK/PEND.
REQ-019 States: IDLE, ISSUE, GAP; VECTOR=0 in IDLE and GAP.
REQ-020 IDLE->ISSUE when RUN=1 and (PEND & MASK)!=0; VECTOR registers the highest-numbered eligible index+1, and that PEND bit clears on the same edge.
REQ-021 ISSUE holds VECTOR constant for exactly HOLD cycles, then ->GAP; GAP lasts exactly GAP cycles, then ->IDLE.
REQ-022 Latency without sync: IRQ first sampled high at edge k -> PEND set at edge k+1 -> VECTOR non-zero after edge k+2 (if IDLE, enabled, RUN=1).
REQ-023 Edge-set and W1C on the same bit in the same cycle: set wins.
REQ-024 Edge on the bit currently being issued during ISSUE re-sets PEND; it is serviced after GAP.
REQ-025 Masked pending bits stay pending; unmasking later makes them eligible next IDLE evaluation.
REQ-026 RUN falling during ISSUE/GAP shall not abort the sequence; new issues wait for RUN=1.

Reset
REQ-027 RESET=1 shall force state IDLE, VECTOR=0, MASK=0, PEND=0, IRQ sample registers=0, counters=0, at any state including mid-ISSUE.
REQ-028 IRQ lines already high when RESET deasserts shall register as an edge only after returning low then high.

Configuration
REQ-029 With INT_CTRL18_SYNC_EN defined, each IRQ line shall pass a two-flop synchronizer before edge detection, adding exactly 2 cycles to REQ-022 latency; reset clears synchronizers.
REQ-030 Without INT_CTRL18_SYNC_EN, IRQ shall be sampled directly by the edge-detect register.

Structure
REQ-031 Package int_ctrl18_pkg shall hold the state enum (IDLE, ISSUE, GAP), register offsets 0/1/2, and NUM_IRQ=15.
REQ-032 Sub-module int_prio15 (combinational 15-to-4 highest-index encoder with valid flag) is natural; all state lives in int_ctrl18.

Verification
REQ-033 MASK=7'h7F written, IRQ[6] pulse, no sync -> VECTOR=7 after edge k+2 for 2 cycles, then 0 for 2, PEND[6]=0.
REQ-034 IRQ[2] and IRQ[9] same cycle, both enabled -> VECTOR=10, then after GAP VECTOR=3.
REQ-035 IRQ[4] with MASK=0 -> VECTOR stays 0, PEND reads 18'o000020; write MASK=18'o000020 -> VECTOR=5.
REQ-036 PEND[4] set, W1C 18'o000020 concurrent with a new IRQ[4] edge -> PEND[4] remains 1.
REQ-037 RESET asserted during ISSUE with VECTOR=7 -> next cycle VECTOR=0, MASK=0, PEND=0, STAT=0.
REQ-038 INT_CTRL18_SYNC_EN defined, RUN=0 then IRQ[0] pulse -> no vector; RUN=1 -> VECTOR=1, with latency k+4 when RUN already high.
